// File: rtl/mac_acc_sched.sv
// mac_acc_sched
//   Time-shares one external W-bit adder among NREQ requesters. A pass takes
//   `len` terms from every requester and keeps one running sum per requester.
//   The requesters are served round-robin, one term per cycle. After the pass,
//   the final sums are streamed out in requester order over a valid/ready port.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start, len        begin a pass (sampled in IDLE only), terms per requester
//   req_valid/ready   per-requester term handshake (ready is one-hot or zero)
//   req_data          packed terms, requester i at [i*W +: W]
//   add_a/b/cin       operands to the shared adder
//   add_so/cout       combinational sum and carry-out returned by the adder
//   res_*             result stream: sum, requester id, sticky overflow
//   busy, done        pass in progress, one-cycle end-of-pass pulse
module mac_acc_sched #(
    parameter int NREQ  = 4,
    parameter int W     = 25,
    parameter int CNT_W = 8,
    parameter int IDW   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    output logic              add_cin,
    input  logic [W-1:0]      add_so,
    input  logic              add_cout,
    output logic              res_valid,
    output logic [W-1:0]      res_data,
    output logic [IDW-1:0]    res_id,
    output logic              res_ovf,
    input  logic              res_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT, S_DONE} state_t;

    state_t           state_q;
    logic [W-1:0]     acc_q [NREQ];
    logic [CNT_W-1:0] rem_q [NREQ];
    logic [NREQ-1:0]  ovf_q;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   k_q;

    logic [IDW-1:0]   ptr_d;
    logic [IDW-1:0]   k_d;
    logic [W-1:0]     term [NREQ];
    logic             gnt_vld;
    logic [IDW-1:0]   gnt_idx;
    logic [IDW-1:0]   cand_idx;
    logic             last_xfer;

    // Unpack the flat term bus into one word per requester.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign term[gi] = req_data[gi*W +: W];
        end
    endgenerate

    // Round-robin arbiter. The loop walks the cyclic offsets from the far end
    // back to the pointer, so the surviving assignment is the first eligible
    // requester at or after the pointer.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        cand_idx = '0;
        if (state_q == S_ACC) begin
            for (int j = NREQ - 1; j >= 0; j--) begin
                cand_idx = IDW'((int'(ptr_q) + j) % NREQ);
                if (req_valid[cand_idx] && (rem_q[cand_idx] != '0)) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand_idx;
                end
            end
        end
    end

    // The pass ends on the transfer that takes the granted requester's last
    // term while every other requester already has nothing left.
    always_comb begin
        last_xfer = gnt_vld;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == gnt_idx) begin
                if (rem_q[i] != CNT_W'(1)) last_xfer = 1'b0;
            end else if (rem_q[i] != '0) begin
                last_xfer = 1'b0;
            end
        end
    end

    always_comb begin
        ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        k_d   = k_q + 1'b1;
    end

    // Adder operands are zero whenever nobody is granted.
    always_comb begin
        req_ready = '0;
        add_a     = '0;
        add_b     = '0;
        if (gnt_vld) begin
            req_ready[gnt_idx] = 1'b1;
            add_a              = acc_q[gnt_idx];
            add_b              = term[gnt_idx];
        end
    end

    assign add_cin   = 1'b0;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign res_valid = (state_q == S_OUT);
    assign res_data  = res_valid ? acc_q[k_q] : '0;
    assign res_id    = res_valid ? k_q : '0;
    assign res_ovf   = res_valid ? ovf_q[k_q] : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            k_q     <= '0;
            ovf_q   <= '0;
            for (int i = 0; i < NREQ; i++) begin
                acc_q[i] <= '0;
                rem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NREQ; i++) begin
                            acc_q[i] <= '0;
                            rem_q[i] <= len;
                        end
                        ovf_q   <= '0;
                        ptr_q   <= '0;
                        k_q     <= '0;
                        state_q <= (len == '0) ? S_OUT : S_ACC;
                    end
                end
                S_ACC: begin
                    if (gnt_vld) begin
                        acc_q[gnt_idx] <= add_so;
                        ovf_q[gnt_idx] <= ovf_q[gnt_idx] | add_cout;
                        rem_q[gnt_idx] <= rem_q[gnt_idx] - 1'b1;
                        ptr_q          <= ptr_d;
                        if (last_xfer) state_q <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        if (k_q == IDW'(NREQ - 1)) state_q <= S_DONE;
                        else                       k_q     <= k_d;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_acc_sched.sv
module tb_mac_acc_sched;
    localparam int NREQ  = 4;
    localparam int W     = 25;
    localparam int CNT_W = 8;
    localparam int IDW   = 2;
    localparam longint MASK = (64'd1 << W) - 1;

    logic              clk;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  len;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic              add_cin;
    logic [W-1:0]      add_so;
    logic              add_cout;
    logic              res_valid;
    logic [W-1:0]      res_data;
    logic [IDW-1:0]    res_id;
    logic              res_ovf;
    logic              res_ready;
    logic              busy;
    logic              done;

    mac_acc_sched #(.NREQ(NREQ), .W(W), .CNT_W(CNT_W), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_so(add_so), .add_cout(add_cout),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
        .res_ovf(res_ovf), .res_ready(res_ready),
        .busy(busy), .done(done)
    );

    // External shared adder.
    logic [W:0] add_full;
    assign add_full = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    assign add_so   = add_full[W-1:0];
    assign add_cout = add_full[W];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: true (unbounded) sums per requester; the reported
    // result is the sum modulo 2^W and overflow is "true sum reached 2^W".
    int     ph;              // 0 idle, 1 accumulate, 2 output, 3 done
    longint msum [NREQ];
    int     mrem [NREQ];
    int     mptr;
    int     mk;

    // Observations for the literal checks.
    int     gq[$];
    longint got_data [NREQ];
    int     got_ovf  [NREQ];
    int     res_cnt;
    int     done_cnt;

    task automatic model_reset();
        ph = 0; mptr = 0; mk = 0;
        for (int i = 0; i < NREQ; i++) begin
            msum[i] = 0;
            mrem[i] = 0;
        end
    endtask

    initial model_reset();

    always @(negedge clk) begin
        int g;
        int left;
        logic [NREQ-1:0] er;
        if (rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_res_data",  res_data, 0);
            chk("rst_res_id",    res_id, 0);
            chk("rst_res_ovf",   res_ovf, 0);
            chk("rst_busy",      busy, 0);
            chk("rst_done",      done, 0);
            chk("rst_add_a",     add_a, 0);
            chk("rst_add_b",     add_b, 0);
            model_reset();
        end else begin
            g = -1;
            if (ph == 1) begin
                for (int j = 0; j < NREQ; j++) begin
                    int c;
                    c = (mptr + j) % NREQ;
                    if (g < 0 && req_valid[c] && mrem[c] > 0) g = c;
                end
            end
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            chk("req_ready", req_ready, er);
            chk("add_a", add_a, (g >= 0) ? (msum[g] & MASK) : 0);
            chk("add_b", add_b, (g >= 0) ? req_data[g*W +: W] : 0);
            chk("add_cin", add_cin, 0);
            chk("busy", busy, ph != 0);
            chk("done", done, ph == 3);
            chk("res_valid", res_valid, ph == 2);
            if (ph == 2) begin
                chk("res_data", res_data, msum[mk] & MASK);
                chk("res_id", res_id, mk);
                chk("res_ovf", res_ovf, (msum[mk] >> W) != 0);
            end

            for (int i = 0; i < NREQ; i++) if (req_ready[i]) gq.push_back(i);
            if (res_valid && res_ready) begin
                got_data[res_id] = res_data;
                got_ovf[res_id]  = res_ovf;
                res_cnt++;
                $display("result id=%0d data=0x%07h ovf=%0b", res_id, res_data, res_ovf);
            end
            if (done) done_cnt++;

            case (ph)
                0: if (start) begin
                    for (int i = 0; i < NREQ; i++) begin
                        msum[i] = 0;
                        mrem[i] = len;
                    end
                    mptr = 0; mk = 0;
                    ph = (len == 0) ? 2 : 1;
                end
                1: if (g >= 0) begin
                    msum[g] += req_data[g*W +: W];
                    mrem[g]--;
                    mptr = (g + 1) % NREQ;
                    left = 0;
                    for (int i = 0; i < NREQ; i++) left += mrem[i];
                    if (left == 0) ph = 2;
                end
                2: if (res_ready) begin
                    if (mk == NREQ - 1) ph = 3;
                    else mk++;
                end
                default: ph = 0;
            endcase
        end
    end

    // vm: 0 all valid, 1 only req2 for c<5, 2 random
    // dm: 0 data i+1, 1 req0 0x1FFFFFF others 0, 2 random, 3 constant 7
    // rm: 0 always ready, 1 random, 2 low for the first 3 output cycles
    task automatic run_pass(input int l, input int vm, input int dm, input int rm,
                            input int abort_at, input int restart_at);
        int c;
        int oc;
        gq.delete();
        res_cnt  = 0;
        done_cnt = 0;
        for (int i = 0; i < NREQ; i++) begin
            got_data[i] = -1;
            got_ovf[i]  = -1;
        end
        start = 1'b1;
        len   = CNT_W'(l);
        @(posedge clk); #1;
        start = 1'b0;
        c  = 0;
        oc = 0;
        while (!done) begin
            if (c > 2000) begin
                total++; bad++;
                $display("FAIL pass_timeout act=%0d exp=<2000", c);
                break;
            end
            if (abort_at > 0 && c == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_req_ready", req_ready, 0);
                chk("abort_busy", busy, 0);
                chk("abort_res_valid", res_valid, 0);
                chk("abort_add_a", add_a, 0);
                chk("abort_add_b", add_b, 0);
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            for (int i = 0; i < NREQ; i++) begin
                case (vm)
                    0: req_valid[i] = 1'b1;
                    1: req_valid[i] = (c < 5) ? (i == 2) : 1'b1;
                    default: req_valid[i] = 1'($urandom_range(0, 1));
                endcase
                case (dm)
                    0: req_data[i*W +: W] = W'(i + 1);
                    1: req_data[i*W +: W] = (i == 0) ? W'(25'h1FFFFFF) : '0;
                    2: req_data[i*W +: W] = $urandom_range(0, 1) ? W'($urandom)
                                                                 : W'($urandom_range(0, 100));
                    default: req_data[i*W +: W] = W'(7);
                endcase
            end
            case (rm)
                0: res_ready = 1'b1;
                1: res_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (res_valid) oc++;
                    res_ready = (oc > 3);
                end
            endcase
            if (restart_at > 0 && c == restart_at) begin
                start = 1'b1;
                len   = CNT_W'(l + 3);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            c++;
        end
        @(posedge clk); #1;
        chk("idle_after_done", busy, 0);
        chk("results_per_pass", res_cnt, NREQ);
        chk("done_pulses", done_cnt, 1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        req_valid = '0;
        req_data  = '0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Round-robin over all requesters, data i+1, three terms each.
        run_pass(3, 0, 0, 0, 0, 0);
        chk("t1_grants", gq.size(), 12);
        for (int i = 0; i < gq.size() && i < 12; i++) chk("t1_order", gq[i], i % NREQ);
        for (int i = 0; i < NREQ; i++) begin
            chk("t1_data", got_data[i], 3 * (i + 1));
            chk("t1_ovf", got_ovf[i], 0);
        end

        // Wrap-around with sticky overflow on requester 0.
        run_pass(2, 0, 1, 0, 0, 0);
        chk("t2_data0", got_data[0], 64'h1FFFFFE);
        chk("t2_ovf0", got_ovf[0], 1);
        for (int i = 1; i < NREQ; i++) begin
            chk("t2_data", got_data[i], 0);
            chk("t2_ovf", got_ovf[i], 0);
        end

        // Zero-length pass: no grants, all-zero results.
        run_pass(0, 0, 0, 0, 0, 0);
        chk("t3_grants", gq.size(), 0);
        for (int i = 0; i < NREQ; i++) chk("t3_data", got_data[i], 0);

        // Only requester 2 valid at first; result port held off for 3 cycles.
        run_pass(4, 1, 0, 2, 0, 0);
        for (int i = 0; i < 4 && i < gq.size(); i++) chk("t4_first_grants", gq[i], 2);
        chk("t4_grants", gq.size(), 16);
        chk("t4_data2", got_data[2], 12);

        // Reset after 5 transfers, then a clean single-term pass.
        run_pass(3, 0, 0, 0, 5, 0);
        chk("t5_no_results", res_cnt, 0);
        chk("t5_no_done", done_cnt, 0);
        @(posedge clk); #1;
        run_pass(1, 0, 3, 0, 0, 0);
        for (int i = 0; i < NREQ; i++) chk("t5_data", got_data[i], 7);

        // Start pulsed mid-pass with a different length is ignored.
        run_pass(2, 0, 0, 0, 0, 2);
        chk("t6_grants", gq.size(), 8);
        for (int i = 0; i < NREQ; i++) chk("t6_data", got_data[i], 2 * (i + 1));

        // Randomized passes against the model.
        for (int p = 0; p < 10; p++) begin
            run_pass($urandom_range(0, 6), 2, 2, 1, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_acc_sched.md
# mac_acc_sched

Accumulation scheduler for the subarray MAC datapath. It time-shares one external 25-bit carry-lookahead adder among NREQ column-group requesters, keeping one running sum per requester. It runs one accumulation pass of `len` terms per requester, then streams the final sums out in requester order over a valid/ready port. It sits between the subarray partial-sum outputs and the MAC result buffer.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 25, datapath width; matches the shared adder
- CNT_W, 8, width of the per-requester term counter and `len`
- IDW, 2, width of `res_id` (clog2(NREQ))

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin pass; sampled only in IDLE
- len  in  CNT_W  terms per requester for this pass; captured on accepted `start`
- req_valid  in  NREQ  per-requester term valid
- req_data  in  NREQ*W  term of requester i in bits [i*W +: W]
- req_ready  out  NREQ  one-hot grant (or zero); a term transfers on valid&ready
- add_a  out  W  adder operand A (granted accumulator)
- add_b  out  W  adder operand B (granted term)
- add_cin  out  1  constant 0
- add_so  in  W  adder sum, combinational from add_a/add_b/add_cin
- add_cout  in  1  adder carry-out
- res_valid  out  1  result valid
- res_data  out  W  final sum of requester `res_id`
- res_id  out  IDW  requester index of the current result
- res_ovf  out  1  sticky unsigned overflow flag for that requester
- res_ready  in  1  result consumer ready
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of pass

## Operation
- States: IDLE, ACC, OUT, DONE.
- IDLE:
  - `start`=1 loads `rem[i]`=`len` for all i.
  - Clears all accumulators and overflow flags.
  - Sets the round-robin pointer to 0.
  - Goes to ACC, or directly to OUT if `len`=0.
- ACC:
  - Each cycle, grant the first requester i at or after the pointer (cyclic) with `req_valid[i]`=1 and `rem[i]`≠0.
  - `req_ready` is one-hot on the grant and zero if no candidate exists. It is combinational from state, pointer, `rem`, and `req_valid`.
  - When a grant is issued: add_a=acc[g], add_b=term[g]. On the clock edge, acc[g]<=add_so, ovf[g]<=ovf[g]|add_cout, rem[g]<=rem[g]-1, pointer<=(g+1) mod NREQ.
  - When no grant is issued, add_a/add_b are 0 and no state changes.
  - A requester with `rem`=0 is never granted, even if valid.
  - When the transfer that makes every `rem` zero occurs, go to OUT.
- Arithmetic:
  - Unsigned, modulo 2^W; the accumulator wraps.
  - Overflow is reported only through the sticky `res_ovf`.
- OUT:
  - Presents index k=0..NREQ-1 in order: res_valid=1, res_data=acc[k], res_id=k, res_ovf=ovf[k].
  - Advances k on res_valid&res_ready.
  - After handshaking k=NREQ-1, go to DONE.
  - Outputs stay stable while res_ready=0.
- DONE: done=1 for one cycle, then IDLE. Accumulators keep their values until the next `start`.
- `start` outside IDLE is ignored.
- `len` changes after capture have no effect.

## Timing
- Reset values (asserted asynchronously):
  - State IDLE, all accumulators, `rem`, and ovf flags 0, pointer 0.
  - req_ready=0, res_valid=0, res_data=0, res_id=0, res_ovf=0, busy=0, done=0, add_a=0, add_b=0, add_cin=0.
- Reset mid-pass abandons the pass; no result or done pulse is emitted.
- `start` at edge t: busy=1 from t+1 and req_ready may assert at t+1.
- One term per cycle aggregate; one adder operation per cycle; no pipeline stage.
- The last term accepted at edge t gives res_valid=1 at t+1 with the final sum.
- Handshake of the last result at edge t gives done=1 during t+1 and busy=0 from t+2.
- `len`=0: OUT is entered at t+1 with all results 0 and ovf 0.

## Test plan
- NREQ=4, len=3, all valid continuously with req_data[i]=i+1 → grant order 0,1,2,3 repeated over 12 cycles; results (0,3),(1,6),(2,9),(3,12), all ovf=0; one done pulse.
- len=2, only req0 active with data 0x1FFFFFF twice; the other requesters get len=2 terms of 0 each → res 0 = 0x1FFFFFE with res_ovf=1; the other results are 0 with ovf=0.
- len=0 start → no req_ready ever asserted; four results of 0 with ids 0..3, then done.
- len=4, only req2 valid for the first 5 cycles (others valid later) → req2 granted every cycle until its rem hits 0 and is never granted again. Holding res_ready=0 for 3 cycles keeps res_data/res_id unchanged.
- Assert rst during ACC after 5 transfers → all outputs 0 in the same cycle. A subsequent len=1 pass with data 7 on each requester returns 7 for each, with no residue.
- Pulse start while busy, with a different len → ignored; the pass completes with the original len.
